// File: rtl/tracer_pkg.sv
// Shared constants, FSM encoding and address helper for the trace-logger dumper.
package tracer_pkg;

  localparam logic [21:0] TRC_ADR_ARM     = 22'd0;
  localparam logic [21:0] TRC_ADR_POSTCNT = 22'd4;
  localparam int          TRC_DEPTH       = 1024;
  localparam int          TRC_PLANE_SHIFT = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CNT  = 3'd1,
    ST_WR_TRIG = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_HOLD = 3'd4,
    ST_FAIL    = 3'd5
  } trc_state_e;

  // Word address of a trace sample: plane selects the block above the depth window.
  function automatic logic [21:0] trc_rd_adr(input logic [3:0] plane, input logic [9:0] idx);
    return (22'(plane) << TRC_PLANE_SHIFT) | 22'(idx);
  endfunction

endpackage

// File: rtl/tracer_dumper_wbm.sv
// Single-request classic Wishbone master with a saturating timeout; reports done/err/rdata.
module tracer_dumper_wbm #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req,
  input  logic        req_we,
  input  logic [21:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [21:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

  logic [7:0] tmo_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wbm_stb_o) begin
        if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          done      <= 1'b1;
          rdata     <= wbm_dat_i;
        end else if (wbm_err_i || wbm_rty_i || tmo_cnt == TMO_LAST) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          err       <= 1'b1;
        end else if (tmo_cnt != TMO_MAX) begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end else if (req) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_adr_o <= req_adr;
        wbm_dat_o <= req_dat;
        wbm_we_o  <= req_we;
        tmo_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/tracer_dumper.sv
// Drives the trace logger slave port: arms the trigger or dumps every plane onto a 32-bit stream.
module tracer_dumper
  import tracer_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [21:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic        arm_i,
  input  logic [31:0] trig_val_i,
  input  logic [9:0]  post_cnt_i,
  input  logic        dump_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] dout_o,
  output logic [3:0]  dout_plane_o,
  output logic        dout_last_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i
);
  localparam int         PLANES     = 1 + DATA_WIDTH / 32;
  localparam logic [3:0] LAST_PLANE = 4'(PLANES - 1);
  localparam logic [9:0] LAST_IDX   = 10'(TRC_DEPTH - 1);

  trc_state_e  state;
  logic [31:0] trig_val;
  logic [3:0]  plane, plane_nxt;
  logic [9:0]  idx, idx_nxt;
  logic        req, req_we;
  logic [21:0] req_adr;
  logic [31:0] req_dat;
  logic        wb_done, wb_err;
  logic [31:0] wb_rdata;

  assign wbm_sel_o = 4'hF;
  assign busy_o    = (state != ST_IDLE);
  assign idx_nxt   = idx + 10'd1;
  assign plane_nxt = (idx == LAST_IDX) ? plane + 4'd1 : plane;

  tracer_dumper_wbm #(.TIMEOUT(TIMEOUT)) u_wbm (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .req       (req),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .done      (wb_done),
    .err       (wb_err),
    .rdata     (wb_rdata),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      trig_val     <= '0;
      plane        <= '0;
      idx          <= '0;
      req          <= 1'b0;
      req_we       <= 1'b0;
      req_adr      <= '0;
      req_dat      <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      dout_o       <= '0;
      dout_plane_o <= '0;
      dout_last_o  <= 1'b0;
      dout_valid_o <= 1'b0;
    end else begin
      req    <= 1'b0;
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arm_i) begin
            trig_val <= trig_val_i;
            err_o    <= 1'b0;
            req      <= 1'b1;
            req_we   <= 1'b1;
            req_adr  <= TRC_ADR_POSTCNT;
            req_dat  <= {22'b0, post_cnt_i};
            state    <= ST_WR_CNT;
          end else if (dump_i) begin
            plane   <= '0;
            idx     <= '0;
            err_o   <= 1'b0;
            req     <= 1'b1;
            req_we  <= 1'b0;
            req_adr <= trc_rd_adr(4'd0, 10'd0);
            state   <= ST_RD_REQ;
          end
        end
        ST_WR_CNT: begin
          if (wb_err) begin
            err_o <= 1'b1;
            state <= ST_FAIL;
          end else if (wb_done) begin
            req     <= 1'b1;
            req_adr <= TRC_ADR_ARM;
            req_dat <= trig_val;
            state   <= ST_WR_TRIG;
          end
        end
        ST_WR_TRIG: begin
          if (wb_err) begin
            err_o <= 1'b1;
            state <= ST_FAIL;
          end else if (wb_done) begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (wb_err) begin
            err_o <= 1'b1;
            state <= ST_FAIL;
          end else if (wb_done) begin
            dout_o       <= wb_rdata;
            dout_plane_o <= plane;
            dout_last_o  <= (plane == LAST_PLANE) && (idx == LAST_IDX);
            dout_valid_o <= 1'b1;
            state        <= ST_RD_HOLD;
          end
        end
        ST_RD_HOLD: begin
          // Next read is only requested once the held word has been taken.
          if (dout_ready_i) begin
            dout_valid_o <= 1'b0;
            if (dout_last_o) begin
              done_o <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              idx     <= idx_nxt;
              plane   <= plane_nxt;
              req     <= 1'b1;
              req_adr <= trc_rd_adr(plane_nxt, idx_nxt);
              state   <= ST_RD_REQ;
            end
          end
        end
        ST_FAIL: begin
          err_o        <= 1'b1;
          dout_valid_o <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tracer_dumper.sv
// Directed bench for tracer_dumper with a tracer slave model and a stream scoreboard.
module tb_tracer_dumper;
  localparam int PLANES = 4;
  localparam int WORDS  = PLANES * 1024;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [21:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic        arm_i = 1'b0, dump_i = 1'b0;
  logic [31:0] trig_val_i = '0;
  logic [9:0]  post_cnt_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] dout_o;
  logic [3:0]  dout_plane_o;
  logic        dout_last_o, dout_valid_o;
  logic        dout_ready_i = 1'b1;

  tracer_dumper dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .arm_i(arm_i), .trig_val_i(trig_val_i), .post_cnt_i(post_cnt_i), .dump_i(dump_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .dout_o(dout_o), .dout_plane_o(dout_plane_o), .dout_last_o(dout_last_o),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tracer slave model: 0 normal, 1 never responds, 2 err on write to adr 0, 3 rty on reads.
  int          slv_mode = 0;
  int          wr_n = 0;
  logic [21:0] wr_adr [8];
  logic [31:0] wr_dat [8];
  logic [31:0] trc_trig = '0;
  logic [9:0]  trc_post = '0;

  always @(negedge wb_clk_i) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = '0;
    if (wbm_cyc_o && wbm_stb_o && !wb_rst_i && slv_mode != 1) begin
      if (slv_mode == 2 && wbm_we_o && wbm_adr_o == 22'd0) wbm_err_i = 1'b1;
      else if (slv_mode == 3 && !wbm_we_o) wbm_rty_i = 1'b1;
      else begin
        wbm_ack_i = 1'b1;
        if (wbm_we_o) begin
          if (wr_n < 8) begin
            wr_adr[wr_n] = wbm_adr_o;
            wr_dat[wr_n] = wbm_dat_o;
          end
          wr_n++;
          if (wbm_adr_o == 22'd4) trc_post = wbm_dat_o[9:0];
          if (wbm_adr_o == 22'd0) trc_trig = wbm_dat_o;
        end else begin
          wbm_dat_i = {4'b0, wbm_adr_o[21:10], 6'b0, wbm_adr_o[9:0]};
        end
      end
    end
  end

  logic rnd_ready = 1'b0;
  always @(posedge wb_clk_i) begin
    #1;
    dout_ready_i = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Bus protocol watch and stream scoreboard.
  int          exp_n = 0, last_cnt = 0, done_cnt = 0, req_n = 0, stb_cycles = 0, proto_bad = 0;
  int          ep, ei;
  logic        prev_stb = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [36:0] prev_word = '0;
  logic [54:0] prev_req = '0;
  logic [36:0] exp_word;

  always @(negedge wb_clk_i) begin
    if (done_o) done_cnt++;
    if (wbm_stb_o) stb_cycles++;
    if (wbm_stb_o && !prev_stb) req_n++;
    if (wbm_stb_o && prev_stb && {wbm_adr_o, wbm_dat_o, wbm_we_o} != prev_req) proto_bad++;
    if (wbm_cyc_o != wbm_stb_o || wbm_sel_o != 4'hF) proto_bad++;
    if (prev_valid && !prev_ready)
      check("stall_hold", {dout_valid_o, dout_last_o, dout_plane_o, dout_o}, {1'b1, prev_word});
    if (dout_valid_o && dout_ready_i) begin
      ep = exp_n / 1024;
      ei = exp_n % 1024;
      exp_word = {exp_n == WORDS - 1, 4'(ep), 32'(ep * 32'h10000 + ei)};
      check("word", {dout_last_o, dout_plane_o, dout_o}, exp_word);
      if (dout_last_o) last_cnt++;
      exp_n++;
    end
    prev_stb   = wbm_stb_o;
    prev_req   = {wbm_adr_o, wbm_dat_o, wbm_we_o};
    prev_valid = dout_valid_o;
    prev_ready = dout_ready_i;
    prev_word  = {dout_last_o, dout_plane_o, dout_o};
  end

  task automatic pulse_arm(input logic [31:0] tv, input logic [9:0] pc);
    @(negedge wb_clk_i);
    trig_val_i = tv;
    post_cnt_i = pc;
    arm_i = 1'b1;
    @(negedge wb_clk_i);
    arm_i = 1'b0;
  endtask

  task automatic pulse_dump();
    @(negedge wb_clk_i);
    dump_i = 1'b1;
    @(negedge wb_clk_i);
    dump_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    @(negedge wb_clk_i);
    check({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic run_dump(input string tag, input int budget, input bit poke_arm);
    int wr_before;
    exp_n = 0; last_cnt = 0; done_cnt = 0;
    wr_before = wr_n;
    pulse_dump();
    if (poke_arm) begin
      repeat (40) @(negedge wb_clk_i);
      pulse_arm(32'h1234_5678, 10'd5);
    end
    wait_idle(tag, budget);
    check({tag, "_words"}, exp_n, WORDS);
    check({tag, "_last_cnt"}, last_cnt, 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_no_writes"}, wr_n, wr_before);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge wb_clk_i);
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
          {3'b000, 4'hF, 22'd0, 32'd0});
    check("rst_status", {busy_o, done_o, err_o}, 3'b000);
    check("rst_stream", {dout_valid_o, dout_last_o, dout_plane_o, dout_o}, 38'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Arm: post count first, then trigger pattern.
    wr_n = 0; done_cnt = 0;
    pulse_arm(32'hDEAD_BEEF, 10'd100);
    wait_idle("arm", 100);
    check("arm_wr_n", wr_n, 2);
    check("arm_wr0", {wr_adr[0], wr_dat[0]}, {22'd4, 32'h0000_0064});
    check("arm_wr1", {wr_adr[1], wr_dat[1]}, {22'd0, 32'hDEAD_BEEF});
    check("arm_trig", trc_trig, 32'hDEAD_BEEF);
    check("arm_post", trc_post, 10'd100);
    check("arm_done_cnt", done_cnt, 1);
    check("arm_err", err_o, 1'b0);

    // Full dump with ready held high; an arm pulse mid-dump must be ignored.
    run_dump("dump_rdy", 30000, 1'b1);

    rnd_ready = 1'b1;
    run_dump("dump_rnd", 70000, 1'b0);
    rnd_ready = 1'b0;

    // Slave never acks a read.
    slv_mode = 1; done_cnt = 0; stb_cycles = 0;
    pulse_dump();
    wait_idle("noack", 400);
    check("noack_stb_cycles", stb_cycles, 255);
    check("noack_err", err_o, 1'b1);
    check("noack_done_cnt", done_cnt, 0);
    check("noack_stb_low", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    slv_mode = 0; done_cnt = 0;
    pulse_arm(32'hA5A5_0001, 10'd7);
    check("rearm_err_clr", err_o, 1'b0);
    wait_idle("rearm", 100);
    check("rearm_done_cnt", done_cnt, 1);
    check("rearm_trig", trc_trig, 32'hA5A5_0001);

    // Bus error on the trigger write.
    slv_mode = 2; done_cnt = 0; req_n = 0;
    pulse_arm(32'hCAFE_F00D, 10'd3);
    wait_idle("arm_err", 100);
    repeat (20) @(negedge wb_clk_i);
    check("arm_err_req_n", req_n, 2);
    check("arm_err_flag", err_o, 1'b1);
    check("arm_err_done_cnt", done_cnt, 0);
    check("arm_err_trig_kept", trc_trig, 32'hA5A5_0001);

    // Retry on a read counts as an error.
    slv_mode = 3; done_cnt = 0; req_n = 0; exp_n = 0;
    pulse_dump();
    wait_idle("rty", 100);
    check("rty_err", err_o, 1'b1);
    check("rty_result", {req_n[7:0], done_cnt[7:0], exp_n[7:0]}, {8'd1, 8'd0, 8'd0});
    slv_mode = 0;

    // Reset in the middle of a dump, then restart from plane 0 idx 0.
    exp_n = 0;
    pulse_dump();
    n = 0;
    while (exp_n < 500 && n < 5000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("rst_mid_reach", exp_n, 500);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst_mid_drop", {wbm_cyc_o, wbm_stb_o, dout_valid_o, busy_o, err_o}, 5'b00000);
    wb_rst_i = 1'b0;
    exp_n = 0;
    pulse_dump();
    n = 0;
    while (exp_n < 16 && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("restart_words", exp_n >= 16, 1'b1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    check("protocol", proto_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
